move_scheduler: RTL

- Sits between the four per-direction button debouncers and the board-update logic of the 2048 game.
- Latches one-cycle "pressed" pulses into per-direction pending bits.
- Grants pending bits one at a time, round-robin, as a move command over a valid/ready handshake.
- After each grant, waits for the board to report the move done, then enforces a cooldown so moves never overlap or stack.

---
 rtl/move_pkg.sv | 24 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/move_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/move_pkg.sv
// ---------------------------------------------------------------------------
// move_pkg
// Shared definitions for the 2048 move scheduler:
//   - direction codes (also the bit index of each direction in pressed/pending)
//   - scheduler state encoding
//   - production cooldown length (about 10 ms at 100 MHz)
// ---------------------------------------------------------------------------
package move_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned COOLDOWN_CYCLES_PROD = 32'd1 << 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker. The search starts one position
// after the last grant and wraps, so the last granted direction has the
// lowest priority.
//
// Ports:
//   req    in  4  request bits (bit index = direction code)
//   last   in  2  previously granted index
//   grant  out 2  first requesting index after last (DIR_UP when none)
//   any    out 1  at least one request is set
// ---------------------------------------------------------------------------
module rr_pick4
  import move_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // Walk offsets from furthest (4, i.e. last itself) to nearest (1); the
  // nearest requesting index is assigned last and therefore wins.
  always_comb begin
    grant = DIR_UP;
    idx   = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
// Latches debounced direction presses into pending bits, grants them one at
// a time (round-robin) as a move command over valid/ready, waits for the
// board to finish the move, then holds off for a cooldown period.
//
// Optional feature macro: MOVE_SCHED_TIMEOUT_EN
//   defined   : WAIT_DONE gives up after TIMEOUT_CYCLES, pulsing timeout
//   undefined : WAIT_DONE waits indefinitely, timeout is tied low
//
// Parameters:
//   COOLDOWN_CYCLES  idle cycles after move_done (0 = none)
//   TIMEOUT_CYCLES   WAIT_DONE limit when the timeout feature is built in
//   CNT_W            width of the shared cycle counter
//
// Ports:
//   clk         in  1  system clock, rising edge
//   rst_n       in  1  asynchronous active-low reset
//   pressed     in  4  one-cycle press pulses (0=up 1=down 2=left 3=right)
//   move_ready  in  1  board logic can accept a move
//   move_done   in  1  one-cycle pulse, board finished the current move
//   move_valid  out 1  move command valid
//   move_dir    out 2  direction of the command
//   pending     out 4  queued directions
//   busy        out 1  scheduler not in IDLE
//   timeout     out 1  one-cycle pulse on done-timeout
// ---------------------------------------------------------------------------
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | nothing in flight; grant as soon as any pending bit is set
// ISSUE     | move_valid high, waiting for move_ready
// WAIT_DONE | command accepted, waiting for move_done (or timeout)
// COOLDOWN  | counting COOLDOWN_CYCLES before the next grant
// ---------------------------------------------------------------------------
module move_scheduler
  import move_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pressed,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] pending,
  output logic       busy,
  output logic       timeout
);

  // The counter never needs to exceed the larger of the two limits; holding
  // it there keeps it from ever wrapping.
  localparam int CNT_LIMIT =
    (COOLDOWN_CYCLES > TIMEOUT_CYCLES) ? COOLDOWN_CYCLES : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_LIMIT);
  localparam logic [CNT_W-1:0] CD_LAST =
    (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;
`ifdef MOVE_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
`endif

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [1:0]       last_grant;
  logic [1:0]       pick;
  logic             pick_any;
  logic [3:0]       grant_mask;

  rr_pick4 u_pick (
    .req   (pending),
    .last  (last_grant),
    .grant (pick),
    .any   (pick_any)
  );

  assign grant_mask = 4'b0001 << pick;

`ifdef MOVE_SCHED_TIMEOUT_EN
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
      busy       <= 1'b0;
      counter    <= '0;
      last_grant <= DIR_RIGHT;
`ifdef MOVE_SCHED_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef MOVE_SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // Presses are latched in every state; the grant branch below
      // overrides this with the clear, still ORing in the press so that a
      // press on the granted bit in the same cycle keeps it pending.
      pending <= pending | pressed;

      case (state)
        IDLE: begin
          if (pick_any) begin
            pending    <= (pending & ~grant_mask) | pressed;
            move_dir   <= pick;
            last_grant <= pick;
            move_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            counter    <= '0;
            state      <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (move_done) begin
            counter <= '0;
            if (COOLDOWN_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= COOLDOWN;
            end
          end
`ifdef MOVE_SCHED_TIMEOUT_EN
          else if (counter == TO_LAST) begin
            timeout_q <= 1'b1;
            counter   <= '0;
            if (COOLDOWN_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= COOLDOWN;
            end
          end else if (counter != CNT_SAT) begin
            counter <= counter + CNT_W'(1);
          end
`endif
        end

        COOLDOWN: begin
          if (counter == CD_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (counter != CNT_SAT) begin
            counter <= counter + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
